// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sequencer state encoding and helpers.
// Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned MUL_W = 2 * CNT_W;

    localparam int unsigned DEF_PIX_DIV     = 2;
    localparam int unsigned DEF_H_VISIBLE   = 640;
    localparam int unsigned DEF_H_FRONT     = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BACK      = 48;
    localparam int unsigned DEF_V_VISIBLE   = 480;
    localparam int unsigned DEF_V_FRONT     = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BACK      = 33;
    localparam int unsigned DEF_SCALE_SHIFT = 2;
    localparam int unsigned DEF_ADDR_W      = 15;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Stage-1 video flags, all registered together.
    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } vga_sync_t;

    localparam vga_sync_t SYNC_IDLE = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

    // Multiply by an elaboration-time constant as a sum of shifted copies.
    function automatic logic [MUL_W-1:0] const_mul(input logic [CNT_W-1:0] a,
                                                   input int unsigned      k);
        logic [MUL_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (k[i]) acc = acc + (MUL_W'(a) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// Scan-timing bus between the frame sequencer and the sync/colour datapath.
// VGA_FRAME_CNT_EN adds the frame_cnt signal.
interface vga_frame_sequencer_if #(
    parameter int unsigned ADDR_W = 15
);
    logic                               enable;
    logic                               pixel_tick;
    logic [vga_timing_pkg::CNT_W-1:0]   h_count;
    logic [vga_timing_pkg::CNT_W-1:0]   v_count;
    logic                               line_start;
    logic                               frame_start;
    logic                               mem_rd_en;
    logic [ADDR_W-1:0]                  mem_addr;
    logic                               video_on;
    logic                               vga_hsync;
    logic                               vga_vsync;
    logic                               busy;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]                        frame_cnt;
`endif

    modport master (
        input  enable,
        output pixel_tick, h_count, v_count, line_start, frame_start,
        output mem_rd_en, mem_addr, video_on, vga_hsync, vga_vsync, busy
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output enable,
        input  pixel_tick, h_count, v_count, line_start, frame_start,
        input  mem_rd_en, mem_addr, video_on, vga_hsync, vga_vsync, busy
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

endinterface

// File: rtl/vga_scan_counter.sv
// Pixel divider plus h/v scan counters; exposes next-cycle values so the
// top can register its stage-0 outputs in step with the tick.
module vga_scan_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV = DEF_PIX_DIV,
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             running,
    input  logic             running_nxt,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             tick_nxt_c,
    output logic [CNT_W-1:0] h_nxt_c,
    output logic [CNT_W-1:0] v_nxt_c,
    output logic             frame_end_c
);

    localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

    // Entering the scan preloads the divider so the first tick is immediate.
    always_comb begin
        div_d = '0;
        h_d   = h_q;
        v_d   = v_q;
        if (running_nxt) begin
            if (!running) begin
                div_d = DIV_LAST;
            end else if (div_q != DIV_LAST) begin
                div_d = div_q + DIV_W'(1);
            end
        end
        tick_d = running_nxt && (div_d == DIV_LAST);
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
        end
    end

    assign pixel_tick  = tick_q;
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign tick_nxt_c  = tick_d;
    assign h_nxt_c     = h_d;
    assign v_nxt_c     = v_d;
    assign frame_end_c = tick_q && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA scan sequencer: run/drain FSM, framebuffer read addressing and
// stage-1 sync/blank registers. VGA_FRAME_CNT_EN adds a 16-bit frame counter.
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int unsigned PIX_DIV     = DEF_PIX_DIV,
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_frame_sequencer_if.master bus
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned FB_W    = H_VISIBLE >> SCALE_SHIFT;

    localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    seq_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    vga_sync_t         sync_q, sync_d;

    logic              running_nxt;
    logic              pix_tick, tick_nxt_c, frame_end_c, visible_nxt;
    logic [CNT_W-1:0]  h_cnt, v_cnt, h_nxt_c, v_nxt_c;

    vga_scan_counter #(
        .PIX_DIV (PIX_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_scan (
        .clk         (clk),
        .reset       (reset),
        .running     (state_q != ST_IDLE),
        .running_nxt (running_nxt),
        .pixel_tick  (pix_tick),
        .h_count     (h_cnt),
        .v_count     (v_cnt),
        .tick_nxt_c  (tick_nxt_c),
        .h_nxt_c     (h_nxt_c),
        .v_nxt_c     (v_nxt_c),
        .frame_end_c (frame_end_c)
    );

    // Run/drain control: a dropped enable finishes the current frame first.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_RUN;
            ST_RUN:   if (!bus.enable) state_d = frame_end_c ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (bus.enable)       state_d = ST_RUN;
                else if (frame_end_c) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign running_nxt = busy_d;

    // Stage 0 is registered from next-cycle counters; stage 1 from the tick's counters.
    always_comb begin
        visible_nxt   = tick_nxt_c && (h_nxt_c < H_VIS_END) && (v_nxt_c < V_VIS_END);
        mem_rd_en_d   = visible_nxt;
        mem_addr_d    = mem_addr_q;
        line_start_d  = tick_nxt_c && (h_nxt_c == '0);
        frame_start_d = line_start_d && (v_nxt_c == '0);
        sync_d        = sync_q;
        if (visible_nxt) begin
            mem_addr_d = ADDR_W'(const_mul(v_nxt_c >> SCALE_SHIFT, FB_W)
                                 + MUL_W'(h_nxt_c >> SCALE_SHIFT));
        end
        if (pix_tick) begin
            sync_d.video_on = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
            sync_d.hsync    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
            sync_d.vsync    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        end else if (state_q == ST_IDLE) begin
            sync_d = SYNC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            sync_q        <= SYNC_IDLE;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_addr_q    <= mem_addr_d;
            sync_q        <= sync_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_start_q);
    end

    always_ff @(posedge clk) begin
        if (reset) frame_cnt_q <= '0;
        else       frame_cnt_q <= frame_cnt_d;
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

    assign bus.pixel_tick  = pix_tick;
    assign bus.h_count     = h_cnt;
    assign bus.v_count     = v_cnt;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.video_on    = sync_q.video_on;
    assign bus.vga_hsync   = sync_q.hsync;
    assign bus.vga_vsync   = sync_q.vsync;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer with a reduced raster (80x18 total) so that
// several full frames fit in a short run.
module tb_vga_frame_sequencer;

    localparam int PD = 2;
    localparam int HV = 64, HF = 4, HS = 8, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int SS = 2;
    localparam int FRAME_CLKS = HT * VT * PD;

    logic clk = 1'b0;
    logic reset;

    vga_frame_sequencer_if #(.ADDR_W(15)) bus ();

    vga_frame_sequencer #(
        .PIX_DIV(PD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SCALE_SHIFT(SS), .ADDR_W(15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int h; int v; } tick_exp_t;
    tick_exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Tick k of a scan enabled at step 0 arrives at step 1 + k*PD.
    task automatic push_ticks(input int first, input int last, input int lag);
        for (int k = first; k <= last; k++)
            sb.push_back('{t: 1 + k * PD + lag, h: k % HT, v: (k / HT) % VT});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.pixel_tick, bus.line_start, bus.frame_start, bus.mem_rd_en,
                 bus.video_on, bus.vga_hsync, bus.vga_vsync} !== 8'b0000_0011) begin
                errors++;
                $display("FAIL reset_flags got=%b exp=00000011", {bus.busy, bus.pixel_tick,
                         bus.line_start, bus.frame_start, bus.mem_rd_en, bus.video_on,
                         bus.vga_hsync, bus.vga_vsync});
            end
            checks++;
            if (bus.h_count !== 10'd0 || bus.v_count !== 10'd0 || bus.mem_addr !== 15'd0) begin
                errors++;
                $display("FAIL reset_counts h=%0d v=%0d addr=%0d exp 0/0/0",
                         bus.h_count, bus.v_count, bus.mem_addr);
            end
        end
        reset = 1'b0;
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.pixel_tick !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold busy=%b tick=%b exp 0/0", bus.busy, bus.pixel_tick);
        end
    endtask

    task automatic test_scan();
        int n, last_ls, last_fs;
        tick_exp_t e;
        do_reset();
        sb.delete();
        bus.enable = 1'b1;
        push_ticks(0, HT * VT + 2 * HT, 0);
        n = 0; last_ls = -1; last_fs = -1;
        while (sb.size() > 0 && n < 2 * FRAME_CLKS + 100) begin
            @(negedge clk);
            n++;
            if (bus.pixel_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scan_extra_tick step=%0d", n);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (n !== e.t || bus.h_count !== 10'(e.h) || bus.v_count !== 10'(e.v)) begin
                        errors++;
                        $display("FAIL scan_tick step=%0d h=%0d v=%0d exp step=%0d h=%0d v=%0d",
                                 n, bus.h_count, bus.v_count, e.t, e.h, e.v);
                    end
                    checks++;
                    if (bus.line_start !== (e.h == 0) || bus.frame_start !== (e.h == 0 && e.v == 0)) begin
                        errors++;
                        $display("FAIL scan_strobes ls=%b fs=%b at h=%0d v=%0d", bus.line_start,
                                 bus.frame_start, e.h, e.v);
                    end
                end
            end else begin
                checks++;
                if (bus.line_start !== 1'b0 || bus.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_strobe_off ls=%b fs=%b exp 0/0", bus.line_start, bus.frame_start);
                end
            end
            if (bus.line_start === 1'b1) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (n - last_ls != HT * PD) begin
                        errors++;
                        $display("FAIL line_period got=%0d exp=%0d", n - last_ls, HT * PD);
                    end
                end
                last_ls = n;
            end
            if (bus.frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (n - last_fs != FRAME_CLKS) begin
                        errors++;
                        $display("FAIL frame_period got=%0d exp=%0d", n - last_fs, FRAME_CLKS);
                    end
                end
                last_fs = n;
            end
        end
        checks++;
        if (sb.size() != 0 || last_fs < 0) begin
            errors++;
            $display("FAIL scan_missing left=%0d last_fs=%0d exp 0 and a frame_start", sb.size(), last_fs);
        end
    endtask

    task automatic test_sync();
        int n;
        logic exp_vid, exp_hs, exp_vs;
        tick_exp_t e;
        do_reset();
        sb.delete();
        bus.enable = 1'b1;
        push_ticks(0, HT * VT - 1, 1);
        n = 0;
        while (sb.size() > 0 && n < FRAME_CLKS + 100) begin
            @(negedge clk);
            n++;
            if (n == sb[0].t) begin
                e = sb.pop_front();
                exp_vid = (e.h < HV) && (e.v < VV);
                exp_hs  = !((e.h >= HV + HF) && (e.h < HV + HF + HS));
                exp_vs  = !((e.v >= VV + VF) && (e.v < VV + VF + VS));
                checks++;
                if (bus.video_on !== exp_vid || bus.vga_hsync !== exp_hs || bus.vga_vsync !== exp_vs) begin
                    errors++;
                    $display("FAIL stage1 h=%0d v=%0d vid/hs/vs=%b%b%b exp %b%b%b", e.h, e.v,
                             bus.video_on, bus.vga_hsync, bus.vga_vsync, exp_vid, exp_hs, exp_vs);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL stage1_timeout left=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_addr();
        int n;
        logic exp_rd;
        logic [14:0] exp_addr, spot;
        tick_exp_t e;
        do_reset();
        sb.delete();
        bus.enable = 1'b1;
        push_ticks(0, HT * VT - 1, 0);
        spot = 15'd33;
        n = 0;
        while (sb.size() > 0 && n < FRAME_CLKS + 100) begin
            @(negedge clk);
            n++;
            if (bus.pixel_tick === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                exp_rd   = (e.h < HV) && (e.v < VV);
                exp_addr = 15'((e.v >> SS) * (HV >> SS) + (e.h >> SS));
                checks++;
                if (bus.mem_rd_en !== exp_rd || (exp_rd && bus.mem_addr !== exp_addr)) begin
                    errors++;
                    $display("FAIL addr h=%0d v=%0d rd=%b addr=%0d exp rd=%b addr=%0d", e.h, e.v,
                             bus.mem_rd_en, bus.mem_addr, exp_rd, exp_addr);
                end
                if (e.h == 5 && e.v == 9) begin
                    checks++;
                    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== spot) begin
                        errors++;
                        $display("FAIL addr_5_9 rd=%b addr=%0d exp rd=1 addr=%0d",
                                 bus.mem_rd_en, bus.mem_addr, spot);
                    end
                end
            end else begin
                checks++;
                if (bus.mem_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL addr_rd_off step=%0d rd=%b exp 0", n, bus.mem_rd_en);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL addr_timeout left=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_drain();
        int n, t_last;
        tick_exp_t e;
        do_reset();
        sb.delete();
        bus.enable = 1'b1;
        push_ticks(0, HT * VT - 1, 0);
        t_last = 1 + (HT * VT - 1) * PD;
        n = 0;
        while (n < t_last + 20) begin
            @(negedge clk);
            n++;
            if (bus.pixel_tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL drain_extra_tick step=%0d h=%0d v=%0d", n, bus.h_count, bus.v_count);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (n !== e.t || bus.h_count !== 10'(e.h) || bus.v_count !== 10'(e.v) || bus.busy !== 1'b1) begin
                        errors++;
                        $display("FAIL drain_tick step=%0d h=%0d v=%0d busy=%b exp step=%0d h=%0d v=%0d busy=1",
                                 n, bus.h_count, bus.v_count, bus.busy, e.t, e.h, e.v);
                    end
                end
            end
            if (n > t_last) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.h_count !== 10'd0 || bus.v_count !== 10'd0) begin
                    errors++;
                    $display("FAIL drain_idle step=%0d busy=%b h=%0d v=%0d exp 0/0/0",
                             n, bus.busy, bus.h_count, bus.v_count);
                end
            end
            // short enable drop at line 2 must not disturb the scan; drop at line 5 stops it
            if (n == 1 + 2 * HT * PD)     bus.enable = 1'b0;
            if (n == 1 + 2 * HT * PD + 7) bus.enable = 1'b1;
            if (n == 1 + 5 * HT * PD)     bus.enable = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_missing left=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int t_target;
        do_reset();
        bus.enable = 1'b1;
        t_target = 1 + (7 * HT + 30) * PD;
        repeat (t_target) @(negedge clk);
        checks++;
        if (bus.pixel_tick !== 1'b1 || bus.h_count !== 10'd30 || bus.v_count !== 10'd7) begin
            errors++;
            $display("FAIL mid_position tick=%b h=%0d v=%0d exp 1/30/7", bus.pixel_tick,
                     bus.h_count, bus.v_count);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.pixel_tick, bus.line_start, bus.frame_start, bus.mem_rd_en,
             bus.video_on, bus.vga_hsync, bus.vga_vsync} !== 8'b0000_0011 ||
            bus.h_count !== 10'd0 || bus.v_count !== 10'd0 || bus.mem_addr !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset flags=%b h=%0d v=%0d addr=%0d exp 00000011/0/0/0",
                     {bus.busy, bus.pixel_tick, bus.line_start, bus.frame_start, bus.mem_rd_en,
                      bus.video_on, bus.vga_hsync, bus.vga_vsync},
                     bus.h_count, bus.v_count, bus.mem_addr);
        end
`ifdef VGA_FRAME_CNT_EN
        checks++;
        if (bus.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset got=%0d exp 0", bus.frame_cnt);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pixel_tick !== 1'b1 || bus.frame_start !== 1'b1 || bus.busy !== 1'b1 ||
            bus.h_count !== 10'd0 || bus.v_count !== 10'd0) begin
            errors++;
            $display("FAIL mid_restart tick=%b fs=%b busy=%b h=%0d v=%0d exp 1/1/1/0/0",
                     bus.pixel_tick, bus.frame_start, bus.busy, bus.h_count, bus.v_count);
        end
`ifdef VGA_FRAME_CNT_EN
        @(negedge clk);
        checks++;
        if (bus.frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL frame_cnt_inc got=%0d exp 1", bus.frame_cnt);
        end
`endif
        do_reset();
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        test_reset();
        test_scan();
        test_sync();
        test_addr();
        test_drain();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
